reg_bus_arbiter: RTL and testbench

Two-requester arbiter for the SoC controller's simple register bus (req/we/addr/be/wdata with registered read data one cycle later). It lets a second master, such as a boot loader or debug port, share the register space behind the AXI-to-memory bridge. Arbitration is round-robin, one access per cycle. An optional bus lock keeps multi-access sequences atomic, for example a two-cycle SPI register access. A lock timeout stops a stalled owner from holding the bus forever.

---
 rtl/reg_bus_arbiter.sv | 129 ++++++++++++
 tb/tb_reg_bus_arbiter.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/reg_bus_arbiter.sv
// rtl/reg_bus_arbiter.sv - two-master round-robin register bus arbiter with bus lock and lock timeout
module reg_bus_arbiter #(
  parameter int AW           = 32,
  parameter int DW           = 64,
  parameter int LOCK_TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_m0_req,
  input  logic              i_m0_we,
  input  logic              i_m0_lock,
  input  logic [AW-1:0]     i_m0_addr,
  input  logic [DW/8-1:0]   i_m0_be,
  input  logic [DW-1:0]     i_m0_wdata,
  input  logic              i_m1_req,
  input  logic              i_m1_we,
  input  logic              i_m1_lock,
  input  logic [AW-1:0]     i_m1_addr,
  input  logic [DW/8-1:0]   i_m1_be,
  input  logic [DW-1:0]     i_m1_wdata,
  output logic              o_m0_gnt,
  output logic              o_m0_rvalid,
  output logic [DW-1:0]     o_m0_rdata,
  output logic              o_m1_gnt,
  output logic              o_m1_rvalid,
  output logic [DW-1:0]     o_m1_rdata,
  output logic              o_req,
  output logic              o_we,
  output logic [AW-1:0]     o_addr,
  output logic [DW/8-1:0]   o_be,
  output logic [DW-1:0]     o_wdata,
  input  logic [DW-1:0]     i_rdata,
  output logic              o_lock_err
);

  localparam int CW = $clog2(LOCK_TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(LOCK_TIMEOUT - 1);

  logic          last;      // index of the most recently granted master
  logic          locked;
  logic          owner;
  logic          pend0;
  logic          pend1;
  logic          lock_err;
  logic [CW-1:0] idle_cnt;

  logic          gnt0;
  logic          gnt1;
  logic          any_gnt;
  logic          gnt_lock;
  logic          timeout;

  // Grant selection: owner-only while locked, round-robin otherwise; nothing during reset
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (rst_n) begin
      if (locked) begin
        gnt0 = i_m0_req && !owner;
        gnt1 = i_m1_req && owner;
      end else if (i_m0_req && i_m1_req) begin
        gnt0 = last;
        gnt1 = !last;
      end else begin
        gnt0 = i_m0_req;
        gnt1 = i_m1_req;
      end
    end
  end

  // While locked, any grant is an owner grant, so an ungranted locked cycle is an idle one
  always_comb begin
    any_gnt  = gnt0 | gnt1;
    gnt_lock = gnt1 ? i_m1_lock : i_m0_lock;
    timeout  = locked && !any_gnt && (idle_cnt == CNT_LAST);
  end

  // Arbitration state, lock ownership, idle counting and response tracking
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last     <= 1'b1;
      locked   <= 1'b0;
      owner    <= 1'b0;
      pend0    <= 1'b0;
      pend1    <= 1'b0;
      lock_err <= 1'b0;
      idle_cnt <= '0;
    end else begin
      pend0    <= gnt0;
      pend1    <= gnt1;
      lock_err <= timeout;
      if (any_gnt) begin
        last <= gnt1;
        if (gnt_lock) begin
          locked <= 1'b1;
          owner  <= gnt1;
        end else begin
          locked <= 1'b0;
        end
      end else if (timeout) begin
        // Hand the next contention to the other master
        locked <= 1'b0;
        last   <= owner;
      end
      if (!locked || any_gnt || timeout) begin
        idle_cnt <= '0;
      end else begin
        idle_cnt <= idle_cnt + CW'(1);
      end
    end
  end

  // Downstream mux defaults to m0 when nobody is granted
  always_comb begin
    o_m0_gnt    = gnt0;
    o_m1_gnt    = gnt1;
    o_req       = any_gnt;
    o_we        = gnt1 ? i_m1_we    : i_m0_we;
    o_addr      = gnt1 ? i_m1_addr  : i_m0_addr;
    o_be        = gnt1 ? i_m1_be    : i_m0_be;
    o_wdata     = gnt1 ? i_m1_wdata : i_m0_wdata;
    o_m0_rvalid = pend0 & rst_n;
    o_m1_rvalid = pend1 & rst_n;
    o_m0_rdata  = i_rdata;
    o_m1_rdata  = i_rdata;
    o_lock_err  = lock_err;
  end

endmodule

// File: tb/tb_reg_bus_arbiter.sv
// tb/tb_reg_bus_arbiter.sv - table-driven self-checking bench for reg_bus_arbiter
module tb_reg_bus_arbiter;

  localparam int AW = 32;
  localparam int DW = 64;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          m0_req, m0_we, m0_lock;
  logic [AW-1:0] m0_addr;
  logic [7:0]    m0_be;
  logic [DW-1:0] m0_wdata;
  logic          m1_req, m1_we, m1_lock;
  logic [AW-1:0] m1_addr;
  logic [7:0]    m1_be;
  logic [DW-1:0] m1_wdata;
  logic          m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
  logic [DW-1:0] m0_rdata, m1_rdata;
  logic          d_req, d_we;
  logic [AW-1:0] d_addr;
  logic [7:0]    d_be;
  logic [DW-1:0] d_wdata;
  logic [DW-1:0] rdata;
  logic          lock_err;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  reg_bus_arbiter #(.AW(AW), .DW(DW), .LOCK_TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_m0_req(m0_req), .i_m0_we(m0_we), .i_m0_lock(m0_lock), .i_m0_addr(m0_addr),
    .i_m0_be(m0_be), .i_m0_wdata(m0_wdata),
    .i_m1_req(m1_req), .i_m1_we(m1_we), .i_m1_lock(m1_lock), .i_m1_addr(m1_addr),
    .i_m1_be(m1_be), .i_m1_wdata(m1_wdata),
    .o_m0_gnt(m0_gnt), .o_m0_rvalid(m0_rvalid), .o_m0_rdata(m0_rdata),
    .o_m1_gnt(m1_gnt), .o_m1_rvalid(m1_rvalid), .o_m1_rdata(m1_rdata),
    .o_req(d_req), .o_we(d_we), .o_addr(d_addr), .o_be(d_be), .o_wdata(d_wdata),
    .i_rdata(rdata), .o_lock_err(lock_err)
  );

  typedef struct {
    logic        rst, r0, r1, k0, k1;
    logic [31:0] a0, a1;
    logic [63:0] rd;
    logic        g0, g1, v0, v1, err;
    logic [31:0] addr;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic rst, logic r0, logic r1, logic k0, logic k1,
                              logic [31:0] a0, logic [31:0] a1, logic [63:0] rd,
                              logic g0, logic g1, logic v0, logic v1, logic err,
                              logic [31:0] addr);
    vec_t v;
    v.rst = rst; v.r0 = r0; v.r1 = r1; v.k0 = k0; v.k1 = k1;
    v.a0 = a0; v.a1 = a1; v.rd = rd;
    v.g0 = g0; v.g1 = g1; v.v0 = v0; v.v1 = v1; v.err = err; v.addr = addr;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic r0, input logic r1,
                       input logic k0, input logic k1);
    @(negedge clk);
    rst_n = rst; m0_req = r0; m1_req = r1; m0_lock = k0; m1_lock = k1;
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    m0_req = 0; m0_we = 0; m0_lock = 0; m0_addr = '0; m0_be = 8'h0F; m0_wdata = '0;
    m1_req = 0; m1_we = 1; m1_lock = 0; m1_addr = '0; m1_be = 8'hF0;
    m1_wdata = 64'hDEAD_BEEF_0000_0001;
    rdata = '0;

    //             rst r0 r1 k0 k1  a0      a1      rd        g0 g1 v0 v1 err addr
    vecs.push_back(mk(0, 1, 1, 0, 0, 'h20,  'h24,  'h0,      0, 0, 0, 0, 0, 'h20));
    vecs.push_back(mk(1, 1, 0, 0, 0, 'h20,  'h24,  'h0,      1, 0, 0, 0, 0, 'h20));
    vecs.push_back(mk(1, 0, 0, 0, 0, 'h20,  'h24,  'h1234,   0, 0, 1, 0, 0, 'h20));
    vecs.push_back(mk(0, 0, 0, 0, 0, 'h20,  'h24,  'h0,      0, 0, 0, 0, 0, 'h20));
    vecs.push_back(mk(1, 1, 1, 0, 0, 'h100, 'h200, 'h11,     1, 0, 0, 0, 0, 'h100));
    vecs.push_back(mk(1, 1, 1, 0, 0, 'h100, 'h200, 'h22,     0, 1, 1, 0, 0, 'h200));
    vecs.push_back(mk(1, 1, 1, 0, 0, 'h100, 'h200, 'h33,     1, 0, 0, 1, 0, 'h100));
    vecs.push_back(mk(1, 1, 1, 0, 0, 'h100, 'h200, 'h44,     0, 1, 1, 0, 0, 'h200));
    vecs.push_back(mk(1, 1, 1, 0, 0, 'h100, 'h200, 'h55,     1, 0, 0, 1, 0, 'h100));
    vecs.push_back(mk(1, 1, 1, 0, 0, 'h100, 'h200, 'h66,     0, 1, 1, 0, 0, 'h200));
    vecs.push_back(mk(1, 0, 1, 0, 1, 'h10,  'h48,  'h77,     0, 1, 0, 1, 0, 'h48));
    vecs.push_back(mk(1, 1, 0, 0, 0, 'h10,  'h48,  'h88,     0, 0, 0, 1, 0, 'h10));
    vecs.push_back(mk(1, 1, 1, 0, 0, 'h10,  'h48,  'h0,      0, 1, 0, 0, 0, 'h48));
    vecs.push_back(mk(1, 1, 0, 0, 0, 'h10,  'h48,  'h99,     1, 0, 0, 1, 0, 'h10));
    vecs.push_back(mk(1, 0, 0, 0, 0, 'h10,  'h48,  'hAB,     0, 0, 1, 0, 0, 'h10));
    vecs.push_back(mk(1, 1, 0, 1, 0, 'h30,  'h40,  'h0,      1, 0, 0, 0, 0, 'h30));
    vecs.push_back(mk(1, 0, 1, 0, 0, 'h30,  'h40,  'hC0,     0, 0, 1, 0, 0, 'h30));
    vecs.push_back(mk(1, 0, 1, 0, 0, 'h30,  'h40,  'h0,      0, 0, 0, 0, 0, 'h30));
    vecs.push_back(mk(1, 0, 1, 0, 0, 'h30,  'h40,  'h0,      0, 0, 0, 0, 0, 'h30));
    vecs.push_back(mk(1, 0, 1, 0, 0, 'h30,  'h40,  'h0,      0, 0, 0, 0, 0, 'h30));
    vecs.push_back(mk(1, 0, 1, 0, 0, 'h30,  'h40,  'h0,      0, 1, 0, 0, 1, 'h40));
    vecs.push_back(mk(1, 0, 0, 0, 0, 'h30,  'h40,  'hD1,     0, 0, 0, 1, 0, 'h30));
    vecs.push_back(mk(1, 0, 1, 0, 1, 'h60,  'h50,  'h0,      0, 1, 0, 0, 0, 'h50));
    vecs.push_back(mk(0, 1, 1, 0, 0, 'h60,  'h50,  'hE0,     0, 0, 0, 0, 0, 'h60));
    vecs.push_back(mk(1, 1, 1, 0, 0, 'h60,  'h50,  'h0,      1, 0, 0, 0, 0, 'h60));
    vecs.push_back(mk(1, 1, 1, 0, 0, 'h60,  'h50,  'hF0,     0, 1, 1, 0, 0, 'h50));

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      rst_n = vecs[i].rst; m0_req = vecs[i].r0; m1_req = vecs[i].r1;
      m0_lock = vecs[i].k0; m1_lock = vecs[i].k1;
      m0_addr = vecs[i].a0; m1_addr = vecs[i].a1; rdata = vecs[i].rd;
      #1;
      chk($sformatf("v%0d m0_gnt", i),    m0_gnt,    vecs[i].g0);
      chk($sformatf("v%0d m1_gnt", i),    m1_gnt,    vecs[i].g1);
      chk($sformatf("v%0d o_req", i),     d_req,     vecs[i].g0 | vecs[i].g1);
      chk($sformatf("v%0d m0_rvalid", i), m0_rvalid, vecs[i].v0);
      chk($sformatf("v%0d m1_rvalid", i), m1_rvalid, vecs[i].v1);
      chk($sformatf("v%0d o_addr", i),    d_addr,    vecs[i].addr);
      chk($sformatf("v%0d lock_err", i),  lock_err,  vecs[i].err);
      if (vecs[i].v0) chk($sformatf("v%0d m0_rdata", i), m0_rdata, vecs[i].rd);
      if (vecs[i].v1) chk($sformatf("v%0d m1_rdata", i), m1_rdata, vecs[i].rd);
    end

    // An owner access in the middle of an idle stretch restarts the timeout count
    m0_addr = 'h70; m1_addr = 'h74;
    drive(1, 1, 0, 1, 0);
    chk("seq lock m0_gnt", m0_gnt, 1'b1);
    chk("seq lock m1_rvalid", m1_rvalid, 1'b1);
    for (int j = 0; j < 3; j++) begin
      drive(1, 0, 1, 0, 0);
      chk($sformatf("seq idleA%0d m1_gnt", j), m1_gnt, 1'b0);
      chk($sformatf("seq idleA%0d lock_err", j), lock_err, 1'b0);
    end
    drive(1, 1, 1, 1, 0);
    chk("seq owner m0_gnt", m0_gnt, 1'b1);
    chk("seq owner m1_gnt", m1_gnt, 1'b0);
    for (int j = 0; j < 4; j++) begin
      drive(1, 0, 1, 0, 0);
      chk($sformatf("seq idleB%0d m1_gnt", j), m1_gnt, 1'b0);
      chk($sformatf("seq idleB%0d lock_err", j), lock_err, 1'b0);
    end
    drive(1, 0, 1, 0, 0);
    chk("seq release lock_err", lock_err, 1'b1);
    chk("seq release m1_gnt", m1_gnt, 1'b1);
    chk("seq release o_we", d_we, 1'b1);
    chk("seq release o_be", d_be, 8'hF0);
    chk("seq release o_wdata", d_wdata, 64'hDEAD_BEEF_0000_0001);
    chk("seq release o_addr", d_addr, 32'h74);
    drive(1, 0, 0, 0, 0);
    chk("seq wack m1_rvalid", m1_rvalid, 1'b1);
    chk("seq wack lock_err", lock_err, 1'b0);

    // Idle bus still presents m0 attributes with o_req low
    chk("seq idle o_req", d_req, 1'b0);
    chk("seq idle o_be", d_be, 8'h0F);
    chk("seq idle o_we", d_we, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
